// File: rtl/adc_pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_pll_seq_pkg
//
// Shared definitions for the ADC PLL lock sequencer:
//   - seq_state_t     : sequencer state encoding
//   - DEF_* constants : default values for the sequencer parameters
//   - max3()          : widest of three counts, used to size the shared counter
//   - count_width()   : bits needed to hold a count value
// -----------------------------------------------------------------------------
package adc_pll_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT_RST = 3'd1,
        WAIT_LOCK  = 3'd2,
        STABLE     = 3'd3,
        RUN        = 3'd4,
        FAULT      = 3'd5
    } seq_state_t;

    // Default parameter values for the sequencer
    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 3;

    // Saturation value for the lock-loss counter
    localparam logic [7:0] LOST_COUNT_MAX = 8'hFF;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // A counter that must reach max_val - 1 needs enough bits for max_val
    function automatic int count_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/adc_pll_sync2.sv
// -----------------------------------------------------------------------------
// adc_pll_sync2
//
// Two-flop synchroniser bringing the raw PLL lock indication into the clk
// domain. Both flops clear on reset so the sequencer sees "not locked" until
// two clean samples have been taken.
//
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output (2 cycles of latency)
// -----------------------------------------------------------------------------
module adc_pll_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// adc_pll_lock_sequencer
//
// Brings up the ADC clock PLL: pulses the PLL reset, waits for lock with a
// timeout, requires lock to stay up for a stable window, then releases the
// ADC-domain reset. Failed attempts are retried up to MAX_RETRIES times
// before latching a fault that only clear_fault can leave.
//
// Parameters:
//   RST_PULSE_CYCLES    : PLL reset pulse length in clk cycles (>= 1)
//   LOCK_TIMEOUT_CYCLES : max cycles to wait for lock after reset release
//   LOCK_STABLE_CYCLES  : consecutive locked cycles needed before ADC release
//   MAX_RETRIES         : failed attempts tolerated before fault (0..15)
//
// Ports:
//   clk             : 50 MHz PLL reference clock
//   reset_n         : asynchronous active-low reset
//   enable          : level request to bring up the ADC clock
//   pll_locked      : raw PLL lock, asynchronous to clk
//   clear_fault     : single-cycle pulse that leaves FAULT
//   pll_rst         : active-high PLL reset
//   adc_reset_n     : active-low reset for the ADC-clock-domain logic
//   ready           : PLL locked and stable, ADC released
//   fault           : retries exhausted
//   retry_count     : failed attempts in the current bring-up
//   lock_lost_count : saturating count of lock losses while in RUN
// -----------------------------------------------------------------------------
module adc_pll_lock_sequencer
    import adc_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pll_locked,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       adc_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_lost_count
);

    // One counter serves every timed state, so it is sized for the longest
    localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES);
    localparam int CNT_W   = count_width(CNT_MAX);

    // Terminal values: a state lasting N cycles ends when the count reads N-1
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic [7:0]       lost_nxt;
    logic             attempt_failed;
    logic             locked_s;

    adc_pll_sync2 u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    // Next-state logic. enable=0 is tested first in every non-FAULT state so
    // it wins over any lock or timeout event in the same cycle. Both a lock
    // timeout and a lock drop during the stable window funnel into
    // attempt_failed, which is resolved once at the end.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        retry_nxt      = retry_count;
        lost_nxt       = lock_lost_count;
        attempt_failed = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = ASSERT_RST;
                    retry_nxt = 4'd0;
                end
            end

            ASSERT_RST: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    attempt_failed = 1'b1;
                end
            end

            STABLE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!locked_s) begin
                    attempt_failed = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                end
            end

            RUN: begin
                cnt_nxt = '0;
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!locked_s) begin
                    state_nxt = ASSERT_RST;
                    retry_nxt = 4'd0;
                    if (lock_lost_count != LOST_COUNT_MAX) begin
                        lost_nxt = lock_lost_count + 8'd1;
                    end
                end
            end

            FAULT: begin
                cnt_nxt = '0;
                if (clear_fault) begin
                    state_nxt = IDLE;
                    retry_nxt = 4'd0;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A failed attempt either retries with a fresh reset pulse or, once
        // the retry budget is spent, latches the fault
        if (attempt_failed) begin
            if (retry_count == RETRY_LIMIT) begin
                state_nxt = FAULT;
            end else begin
                state_nxt = ASSERT_RST;
                retry_nxt = retry_count + 4'd1;
            end
        end

        // Every state entry starts its count from zero
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    // State, counters and outputs. Outputs are decoded from the next state so
    // they change on the same edge as the state they belong to, with no
    // extra cycle of lag and no combinational paths to the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            retry_count     <= 4'd0;
            lock_lost_count <= 8'd0;
            pll_rst         <= 1'b1;
            adc_reset_n     <= 1'b0;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            retry_count     <= retry_nxt;
            lock_lost_count <= lost_nxt;
            pll_rst         <= (state_nxt == IDLE) || (state_nxt == ASSERT_RST) ||
                               (state_nxt == FAULT);
            adc_reset_n     <= (state_nxt == RUN);
            ready           <= (state_nxt == RUN);
            fault           <= (state_nxt == FAULT);
        end
    end

endmodule

// File: doc/adc_pll_lock_sequencer.md
ADC_PLL_LOCK_SEQUENCER -- requirements
Module: adc_pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16: PLL reset pulse length, in clk cycles (≥1).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000: maximum wait for lock after reset release.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive locked cycles required before ADC release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed lock attempts tolerated before fault (0..15).
REQ-005 SHALL have port clk, input, 1: single clock (50 MHz PLL reference domain).
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1: level request to bring up the ADC clock.
REQ-008 SHALL have port pll_locked, input, 1: raw PLL lock, asynchronous to clk.
REQ-009 SHALL have port clear_fault, input, 1: single-cycle pulse that leaves FAULT.
REQ-010 SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-011 SHALL have port adc_reset_n, output, 1: active-low reset to the ADC-clock-domain logic.
REQ-012 SHALL have port ready, output, 1: PLL locked and stable; ADC released.
REQ-013 SHALL have port fault, output, 1: retries exhausted.
REQ-014 SHALL have port retry_count, output, 4: failed attempts in the current bring-up.
REQ-015 SHALL have port lock_lost_count, output, 8: saturating count of lock losses while in RUN.

Function
REQ-016 SHALL synchronise pll_locked through 2 flops; all decisions use locked_s, which adds 2 cycles of latency.
REQ-017 SHALL implement states IDLE, ASSERT_RST, WAIT_LOCK, STABLE, RUN and FAULT; all outputs SHALL be registered and decoded from the next state.
REQ-018 SHALL behave in IDLE as follows: pll_rst=1, adc_reset_n=0, ready=0. When enable=1, it SHALL clear retry_count and go to ASSERT_RST.
REQ-019 SHALL behave in ASSERT_RST as follows: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
REQ-020 SHALL behave in WAIT_LOCK as follows: pll_rst=0 and a timeout counter runs. When locked_s=1, go to STABLE. After LOCK_TIMEOUT_CYCLES cycles without lock, this counts as a failed attempt.
REQ-021 SHALL behave in STABLE as follows: count consecutive cycles of locked_s=1. At LOCK_STABLE_CYCLES, go to RUN. If locked_s=0 before then, this counts as a failed attempt.
REQ-022 SHALL handle a failed attempt as follows: if retry_count==MAX_RETRIES, go to FAULT; otherwise increment retry_count and go to ASSERT_RST.
REQ-023 SHALL behave in RUN as follows: adc_reset_n=1, ready=1, pll_rst=0. When locked_s=0, adc_reset_n=0 and ready=0 in the next cycle, lock_lost_count SHALL increment (saturating at 255), retry_count SHALL clear, and the state SHALL go to ASSERT_RST.
REQ-024 SHALL behave in FAULT as follows: fault=1, pll_rst=1, adc_reset_n=0. It SHALL remain in FAULT regardless of enable until clear_fault=1, then go to IDLE with retry_count cleared and fault=0.
REQ-025 SHALL, on enable=0 in any state other than FAULT, go to IDLE on the next edge; enable=0 SHALL take priority over simultaneous lock or timeout events.
REQ-026 SHALL load a counter to zero on every state entry, so each state starts its count from zero.
REQ-027 SHALL ignore clear_fault outside FAULT.
REQ-028 SHALL hold lock_lost_count through IDLE and FAULT; only reset_n clears it.

Reset
REQ-029 SHALL, while reset_n=0, force state=IDLE, pll_rst=1, adc_reset_n=0, ready=0, fault=0, retry_count=0, lock_lost_count=0, counters=0, sync flops=0.
REQ-030 SHALL, on reset mid-operation, abort any state immediately; outputs SHALL take their reset values asynchronously.

Structure
REQ-031 SHALL place the state enum and a default-parameter constants block in package adc_pll_seq_pkg.
REQ-032 SHALL instantiate sub-module adc_pll_sync2 (2-flop synchroniser, async active-low reset) for pll_locked.
REQ-033 SHALL use one shared counter sized to the widest of the three count parameters.

Verification (the bench SHALL use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-034 SHALL cover nominal bring-up: enable=1, with pll_locked rising 10 cycles after pll_rst falls. Required response: pll_rst high for 4 cycles, then ready=1 and adc_reset_n=1 exactly 2+8 cycles after the rise (±1), with retry_count=0.
REQ-035 SHALL cover retry exhaustion: enable=1 with pll_locked held at 0. Required response: 3 reset pulses, then fault=1 after the 3rd timeout and retry_count=2. A subsequent clear_fault=1 with enable=0 SHALL give IDLE and fault=0.
REQ-036 SHALL cover lock glitch in STABLE: locked_s drops at stable count 5. Required response: retry_count=1, a new 4-cycle pll_rst pulse, and ready stays 0.
REQ-037 SHALL cover lock loss in RUN: drop pll_locked. Required response: ready=0 within 3 cycles, lock_lost_count increments by 1, and re-lock gives ready=1 again. 260 such losses SHALL leave lock_lost_count=255.
REQ-038 SHALL cover enable priority: enable=0 in the same cycle as the WAIT_LOCK timeout. Required response: next state IDLE and retry_count unchanged.
REQ-039 SHALL cover async reset: assert reset_n=0 in RUN for half a cycle. Required response: all outputs at reset values before the next clk edge.
